serial_word_rx: RTL and testbench

Serial-to-parallel word receiver. It is the receive end of the serial link driven by our `shiftreg` transmitter, with matching `WIDTH` and `LEFT` settings. It samples `sdata_in` on each `shift_in` strobe and assembles `WIDTH`-bit words, honouring the transmitter's bit order. Each completed word goes into a one-entry holding register, which the consumer drains through a valid/ready handshake, with sticky overrun detection.

---
 rtl/serial_word_rx.sv | 100 ++++++++++
 tb/tb_serial_word_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: assembles WIDTH-bit words from a strobed bit stream
// and hands them to a consumer through a one-entry valid/ready holding register.
module serial_word_rx #(
    parameter int WIDTH = 10,
    parameter bit LEFT  = 1'b0
) (
    input  logic             clock_in,
    input  logic             n_reset_in,
    input  logic             frame_in,
    input  logic             shift_in,
    input  logic             sdata_in,
    output logic [WIDTH-1:0] pdata_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             overrun_out,
    input  logic             clear_in,
    output logic             busy_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] sr_shifted;
    logic             strobe;
    logic             complete;
    logic             hold_free;
    logic             load;
    logic             drop;

    // Bit order must mirror the transmitter's shift direction.
    if (LEFT) begin : g_msb_first
        assign sr_shifted = {sr_q[WIDTH-2:0], sdata_in};
    end else begin : g_lsb_first
        assign sr_shifted = {sdata_in, sr_q[WIDTH-1:1]};
    end

    assign strobe    = frame_in & shift_in;
    assign complete  = strobe & (cnt_q == LAST_BIT);
    // A word leaving on this same edge frees the slot for the arriving one.
    assign hold_free = ~valid_q | ready_in;
    assign load      = complete & hold_free;
    assign drop      = complete & ~hold_free;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (!frame_in) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_in) begin
            sr_d  = sr_shifted;
            cnt_d = complete ? '0 : cnt_q + 1'b1;
        end

        if (load) begin
            hold_d  = sr_shifted;
            valid_d = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_in) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pdata_out   = hold_q;
    assign valid_out   = valid_q;
    assign overrun_out = overrun_q;
    assign busy_out    = (cnt_q != '0);

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench: an LSB-first and an MSB-first receiver share one bit stream; expected
// words are queued by the stimulus and checked by per-instance monitors on each load.
module tb_serial_word_rx;

    localparam int W = 10;

    logic clk = 1'b0;
    logic n_reset = 1'b1;
    logic frame = 1'b0, shift = 1'b0, sdata = 1'b0, ready = 1'b0, clear = 1'b0;

    logic [W-1:0] pdata_l, pdata_m;
    logic         valid_l, valid_m, ovr_l, ovr_m, busy_l, busy_m;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_l[$];
    logic [W-1:0] q_m[$];

    always #5 clk = ~clk;

    serial_word_rx #(.WIDTH(W), .LEFT(1'b0)) dut_lsb (
        .clock_in(clk), .n_reset_in(n_reset), .frame_in(frame), .shift_in(shift),
        .sdata_in(sdata), .pdata_out(pdata_l), .valid_out(valid_l), .ready_in(ready),
        .overrun_out(ovr_l), .clear_in(clear), .busy_out(busy_l)
    );

    serial_word_rx #(.WIDTH(W), .LEFT(1'b1)) dut_msb (
        .clock_in(clk), .n_reset_in(n_reset), .frame_in(frame), .shift_in(shift),
        .sdata_in(sdata), .pdata_out(pdata_m), .valid_out(valid_m), .ready_in(ready),
        .overrun_out(ovr_m), .clear_in(clear), .busy_out(busy_m)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = w[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs settle 1ns after the rising edge.
    task automatic step(input logic f, input logic s, input logic d, input logic r, input logic c);
        @(negedge clk);
        frame = f; shift = s; sdata = d; ready = r; clear = c;
        @(posedge clk);
        #1;
    endtask

    // Bit i of w is the i-th bit on the wire.
    task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b1, w[i], rdy_last && (i == W - 1), 1'b0);
            chk1("busy_lsb", busy_l, i < W - 1);
            chk1("busy_msb", busy_m, i < W - 1);
            if (i < W - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    chk1("gap_valid_lsb", valid_l, 1'b0);
                    chk1("gap_valid_msb", valid_m, 1'b0);
                end
            end
        end
    endtask

    task automatic expect_word(input logic [W-1:0] w);
        q_l.push_back(w);
        q_m.push_back(rev(w));
    endtask

    initial begin : mon_lsb
        logic pv;
        logic [W-1:0] e;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (valid_l && (!pv || ready)) begin
                checks++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL mon_lsb unexpected word actual=%h", pdata_l);
                end else begin
                    e = q_l.pop_front();
                    if (pdata_l !== e) begin
                        errors++;
                        $display("FAIL mon_lsb word actual=%h required=%h", pdata_l, e);
                    end
                end
            end
            pv = valid_l;
        end
    end

    initial begin : mon_msb
        logic pv;
        logic [W-1:0] e;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (valid_m && (!pv || ready)) begin
                checks++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL mon_msb unexpected word actual=%h", pdata_m);
                end else begin
                    e = q_m.pop_front();
                    if (pdata_m !== e) begin
                        errors++;
                        $display("FAIL mon_msb word actual=%h required=%h", pdata_m, e);
                    end
                end
            end
            pv = valid_m;
        end
    end

    initial begin
        #1 n_reset = 1'b0;
        #2;
        chk("rst_pdata_lsb", pdata_l, 10'h000);
        chk1("rst_valid_lsb", valid_l, 1'b0);
        chk1("rst_ovr_lsb", ovr_l, 1'b0);
        chk1("rst_busy_lsb", busy_l, 1'b0);
        chk("rst_pdata_msb", pdata_m, 10'h000);
        chk1("rst_valid_msb", valid_m, 1'b0);
        @(negedge clk) n_reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first word, back-to-back strobes
        expect_word(10'h2A5);
        send_word(10'h2A5, 0, 1'b0);
        chk1("t1_valid", valid_l, 1'b1);
        chk("t1_pdata_lsb", pdata_l, 10'h2A5);
        chk("t1_pdata_msb", pdata_m, 10'h295);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("t1_consume", valid_l, 1'b0);

        // MSB-first word with 3 idle cycles between strobes
        expect_word(10'h295);
        send_word(10'h295, 3, 1'b0);
        chk("t2_pdata_msb", pdata_m, 10'h2A5);
        chk1("t2_valid_msb", valid_m, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("t2_consume", valid_m, 1'b0);

        // Overrun with ready held low
        expect_word(10'h155);
        send_word(10'h155, 0, 1'b0);
        send_word(10'h0F0, 0, 1'b0);
        chk("t3_pdata_lsb", pdata_l, 10'h155);
        chk("t3_pdata_msb", pdata_m, 10'h2AA);
        chk1("t3_ovr_lsb", ovr_l, 1'b1);
        chk1("t3_ovr_msb", ovr_m, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk1("t3_clear", ovr_l, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("t3_consume", valid_l, 1'b0);

        // Consume and load on the same edge
        expect_word(10'h155);
        send_word(10'h155, 0, 1'b0);
        expect_word(10'h0F0);
        send_word(10'h0F0, 0, 1'b1);
        chk1("t4_valid", valid_l, 1'b1);
        chk("t4_pdata_lsb", pdata_l, 10'h0F0);
        chk("t4_pdata_msb", pdata_m, 10'h03C);
        chk1("t4_ovr", ovr_l, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("t4_consume", valid_l, 1'b0);

        // Frame abort after 4 bits, shift held high during the abort
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk1("t5_busy_partial", busy_l, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk1("t5_busy_abort_lsb", busy_l, 1'b0);
        chk1("t5_busy_abort_msb", busy_m, 1'b0);
        chk1("t5_no_valid", valid_l, 1'b0);
        expect_word(10'h3FF);
        send_word(10'h3FF, 0, 1'b0);
        chk("t5_pdata", pdata_l, 10'h3FF);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word with a held word and overrun pending
        expect_word(10'h155);
        send_word(10'h155, 0, 1'b0);
        send_word(10'h0F0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i[0], 1'b0, 1'b0);
        chk1("t6_pre_busy", busy_l, 1'b1);
        chk1("t6_pre_ovr", ovr_l, 1'b1);
        chk1("t6_pre_valid", valid_l, 1'b1);
        #2;
        n_reset = 1'b0;
        shift = 1'b0;
        #1;
        chk("t6_rst_pdata_lsb", pdata_l, 10'h000);
        chk("t6_rst_pdata_msb", pdata_m, 10'h000);
        chk1("t6_rst_valid_lsb", valid_l, 1'b0);
        chk1("t6_rst_valid_msb", valid_m, 1'b0);
        chk1("t6_rst_ovr_lsb", ovr_l, 1'b0);
        chk1("t6_rst_ovr_msb", ovr_m, 1'b0);
        chk1("t6_rst_busy_lsb", busy_l, 1'b0);
        chk1("t6_rst_busy_msb", busy_m, 1'b0);
        @(negedge clk) n_reset = 1'b1;
        expect_word(10'h2A5);
        send_word(10'h2A5, 0, 1'b0);
        chk("t6_pdata_lsb", pdata_l, 10'h2A5);
        chk("t6_pdata_msb", pdata_m, 10'h295);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("queue_lsb_left", W'(q_l.size()), 10'h000);
        chk("queue_msb_left", W'(q_m.size()), 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
